// File: rtl/sha256_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// sha256_stream_arbiter_if
//   Bundles every signal between the stream arbiter, its requesters, the shared
//   sha256 core and the digest consumer.
//   master : arbiter view (drives req_ready, core_*, hash_*, busy)
//   slave  : environment view (requesters, core and consumer)
//   Requester fields are packed per requester i: data at [32i+31:32i],
//   numbyte at [2i+1:2i], one bit each for valid/last/ready.
// ---------------------------------------------------------------------------
interface sha256_stream_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*2-1:0]  req_numbyte;
  logic [NREQ-1:0]    req_ready;
  logic               core_init;
  logic [31:0]        core_data;
  logic               core_valid;
  logic               core_last;
  logic [1:0]         core_numbyte;
  logic               core_ready;
  logic               core_out_valid;
  logic [255:0]       core_hash;
  logic [255:0]       hash_data;
  logic [IDW-1:0]     hash_id;
  logic               hash_err;
  logic               hash_valid;
  logic               hash_ready;
  logic               busy;

  modport master (
    input  req_data, req_valid, req_last, req_numbyte,
    output req_ready,
    output core_init, core_data, core_valid, core_last, core_numbyte,
    input  core_ready, core_out_valid, core_hash,
    output hash_data, hash_id, hash_err, hash_valid,
    input  hash_ready,
    output busy
  );

  modport slave (
    output req_data, req_valid, req_last, req_numbyte,
    input  req_ready,
    input  core_init, core_data, core_valid, core_last, core_numbyte,
    output core_ready, core_out_valid, core_hash,
    input  hash_data, hash_id, hash_err, hash_valid,
    output hash_ready,
    input  busy
  );
endinterface

// File: rtl/sha256_stream_arbiter.sv
// ---------------------------------------------------------------------------
// sha256_stream_arbiter
//   Shares one sha256 core among NREQ word-stream requesters, one whole message
//   per grant, round-robin. Per grant: pulse core_init, forward words until the
//   last one, wait for the digest (or time out), then present the digest tagged
//   with the requester id until the consumer takes it.
// Ports
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : sha256_stream_arbiter_if.master (requester, core and result signals)
// ---------------------------------------------------------------------------
module sha256_stream_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int WAIT_MAX = 1023
) (
  input logic                     clk,
  input logic                     rst,
  sha256_stream_arbiter_if.master bus
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_FEED = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [IDW-1:0] rr_ptr_r;
  logic [IDW-1:0] grant_r;
  logic [IDW-1:0] pick_s;
  logic [IDW-1:0] idx_s;
  logic           found_s;
  logic           hit_s;
  logic [CW-1:0]  wait_cnt_r;
  logic [255:0]   hash_data_r;
  logic           hash_err_r;
  logic           accept_s;
  logic           last_s;
  logic           timeout_s;
  logic [NREQ-1:0] req_ready_s;
  logic [31:0]    core_data_s;
  logic           core_valid_s;
  logic           core_last_s;
  logic [1:0]     core_numbyte_s;

  assign accept_s  = (state_r == S_FEED) & bus.req_valid[grant_r] & bus.core_ready;
  assign last_s    = bus.req_last[grant_r];
  assign timeout_s = (wait_cnt_r == CW'(WAIT_MAX));

  // Round-robin pick: first valid requester starting just after rr_ptr_r, wrapping.
  always_comb begin
    pick_s  = grant_r;
    found_s = 1'b0;
    idx_s   = {IDW{1'b0}};
    hit_s   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s   = IDW'((int'(rr_ptr_r) + k) % NREQ);
      hit_s   = !found_s && bus.req_valid[idx_s];
      pick_s  = hit_s ? idx_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a digest arriving on the timeout cycle still wins.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (found_s) state_s = S_INIT; else state_s = S_IDLE;
      S_INIT:  state_s = S_FEED;
      S_FEED:  if (accept_s && last_s) state_s = S_WAIT; else state_s = S_FEED;
      S_WAIT:  if (bus.core_out_valid || timeout_s) state_s = S_DONE; else state_s = S_WAIT;
      S_DONE:  if (bus.hash_ready) state_s = S_IDLE; else state_s = S_DONE;
      default: state_s = S_IDLE;
    endcase
  end

  // Grant, wait counter, digest capture and round-robin pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r    <= IDW'(NREQ - 1);
      grant_r     <= {IDW{1'b0}};
      wait_cnt_r  <= {CW{1'b0}};
      hash_data_r <= 256'd0;
      hash_err_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (found_s) grant_r <= pick_s;
          else         grant_r <= grant_r;
        end
        S_FEED: wait_cnt_r <= {CW{1'b0}};
        S_WAIT: begin
          if (bus.core_out_valid) begin
            hash_data_r <= bus.core_hash;
            hash_err_r  <= 1'b0;
          end else if (timeout_s) begin
            hash_data_r <= 256'd0;
            hash_err_r  <= 1'b1;
          end else begin
            wait_cnt_r  <= wait_cnt_r + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.hash_ready) rr_ptr_r <= grant_r;
          else                rr_ptr_r <= rr_ptr_r;
        end
        default: grant_r <= grant_r;
      endcase
    end
  end

  // Output decode: only the granted requester sees core_ready, and only in FEED.
  always_comb begin
    req_ready_s    = {NREQ{1'b0}};
    core_data_s    = 32'd0;
    core_valid_s   = 1'b0;
    core_last_s    = 1'b0;
    core_numbyte_s = 2'd0;
    if (state_r == S_FEED) begin
      req_ready_s[grant_r] = bus.core_ready;
      core_data_s          = bus.req_data[int'(grant_r)*32 +: 32];
      core_valid_s         = bus.req_valid[grant_r];
      core_last_s          = bus.req_last[grant_r];
      core_numbyte_s       = bus.req_numbyte[int'(grant_r)*2 +: 2];
    end else begin
      core_valid_s = 1'b0;
    end
  end

  assign bus.req_ready    = req_ready_s;
  assign bus.core_init    = (state_r == S_INIT);
  assign bus.core_data    = core_data_s;
  assign bus.core_valid   = core_valid_s;
  assign bus.core_last    = core_last_s;
  assign bus.core_numbyte = core_numbyte_s;
  assign bus.hash_data    = hash_data_r;
  assign bus.hash_id      = grant_r;
  assign bus.hash_err     = hash_err_r;
  assign bus.hash_valid   = (state_r == S_DONE);
  assign bus.busy         = (state_r != S_IDLE);
endmodule

// File: tb/tb_sha256_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sha256_stream_arbiter
//   Self-checking bench: per-requester word queues drive the streams, a small
//   core model folds accepted words into a digest, and a scoreboard of
//   expected (id, err, digest) results is filled when messages are queued.
// ---------------------------------------------------------------------------
module tb_sha256_stream_arbiter;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int WAIT_MAX = 8;

  typedef struct packed {
    logic        last;
    logic [1:0]  nb;
    logic [31:0] data;
  } word_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           err;
    logic [255:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_stream_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  sha256_stream_arbiter #(.NREQ(NREQ), .IDW(IDW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_t          rq [NREQ][$];
  exp_t           sb [$];
  int             checks = 0;
  int             failures = 0;
  logic [NREQ-1:0] fire_r = '0;
  int             acc_cnt [NREQ];
  int             owner = -1;
  int             init_cnt = 0;
  logic           inited = 1'b0;
  logic [31:0]    core_acc = 32'd0;
  logic [255:0]   core_digest = 256'd0;
  int             pend = 0;
  int             core_delay = 2;
  int             ready_mode = 0;
  logic           rdy_t = 1'b0;
  logic           hr_en = 1'b1;
  int             tcnt = 0;
  int             t_acc = 0;
  int             t_hv = 0;
  logic           hv_prev = 1'b0;
  logic           hv_hold = 1'b0;
  logic [255:0]   hd_prev = 256'd0;
  logic [IDW-1:0] hid_prev = '0;
  logic           herr_prev = 1'b0;

  task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mix(input logic [31:0] acc, input word_t w);
    return (acc * 32'd33) ^ w.data ^ {29'd0, w.last, w.nb};
  endfunction

  function automatic logic [255:0] digest(input logic [31:0] acc);
    return {8{acc ^ 32'h6a09e667}} ^ {224'd0, acc};
  endfunction

  function automatic bit all_idle();
    bit r;
    r = (sb.size() == 0) && !bus.busy;
    for (int i = 0; i < NREQ; i++) r = r && (rq[i].size() == 0);
    return r;
  endfunction

  // One clock: drive at the falling edge, sample 4 time units later.
  task automatic tick();
    logic [NREQ*32-1:0] d;
    logic [NREQ-1:0]    v;
    logic [NREQ-1:0]    l;
    logic [NREQ*2-1:0]  nb;
    logic [255:0]       junk;
    word_t              cw;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (fire_r[i]) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        v[i] = 1'b1; d[32*i +: 32] = rq[i][0].data;
        l[i] = rq[i][0].last; nb[2*i +: 2] = rq[i][0].nb;
      end else begin
        v[i] = 1'b0; d[32*i +: 32] = $urandom;
        l[i] = 1'($urandom); nb[2*i +: 2] = 2'($urandom);
      end
    end
    bus.req_data = d; bus.req_valid = v; bus.req_last = l; bus.req_numbyte = nb;
    if (ready_mode == 0) rdy_t = 1'b1;
    else rdy_t = ~rdy_t;
    bus.core_ready = rdy_t;
    for (int j = 0; j < 8; j++) junk[32*j +: 32] = $urandom;
    bus.core_out_valid = 1'b0;
    bus.core_hash = junk;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.core_out_valid = 1'b1;
        bus.core_hash = core_digest;
      end
    end
    bus.hash_ready = hr_en;
    tcnt++;
    #4;
    fire_r = bus.req_valid & bus.req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (fire_r[i]) begin
        if (owner < 0) owner = i;
        check_value("msg_lock", i, owner);
        check_value("core_data", bus.core_data, rq[i][0].data);
        check_value("core_last", bus.core_last, rq[i][0].last);
        check_value("core_numbyte", bus.core_numbyte, rq[i][0].nb);
        acc_cnt[i]++;
        if (rq[i][0].last) owner = -1;
      end
    end
    if (bus.core_init) begin
      init_cnt++; inited = 1'b1; core_acc = 32'd0;
    end
    if (bus.core_valid && bus.core_ready) begin
      check_value("init_first", inited, 1'b1);
      cw.last = bus.core_last; cw.nb = bus.core_numbyte; cw.data = bus.core_data;
      core_acc = mix(core_acc, cw);
      if (bus.core_last) begin
        inited = 1'b0; core_digest = digest(core_acc); pend = core_delay; t_acc = tcnt;
      end
    end
    if (hv_hold) begin
      check_value("hold_valid", bus.hash_valid, 1'b1);
      check_value("hold_data", bus.hash_data, hd_prev);
      check_value("hold_id", bus.hash_id, hid_prev);
      check_value("hold_err", bus.hash_err, herr_prev);
    end
    if (bus.hash_valid && !hv_prev) t_hv = tcnt;
    hv_prev = bus.hash_valid;
    hv_hold = 1'b0;
    if (bus.hash_valid && bus.hash_ready) begin
      if (sb.size() == 0) begin
        check_value("sb_empty", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_value("hash_id", bus.hash_id, e.id);
        check_value("hash_err", bus.hash_err, e.err);
        check_value("hash_data", bus.hash_data, e.data);
      end
    end else if (bus.hash_valid) begin
      hv_hold = 1'b1; hd_prev = bus.hash_data; hid_prev = bus.hash_id; herr_prev = bus.hash_err;
    end
  endtask

  task automatic send(input int id, input int n, input logic [31:0] base,
                      input logic [1:0] nbl, input bit err_exp);
    logic [31:0] acc;
    word_t       w;
    exp_t        e;
    acc = 32'd0;
    for (int k = 0; k < n; k++) begin
      w.data = base ^ (32'h01010101 * k);
      w.last = (k == n - 1);
      w.nb   = w.last ? nbl : 2'd0;
      rq[id].push_back(w);
      acc = mix(acc, w);
    end
    e.id = IDW'(id); e.err = err_exp; e.data = err_exp ? 256'd0 : digest(acc);
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_value("budget", 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_busy"}, bus.busy, 1'b0);
    check_value({tag, "_req_ready"}, bus.req_ready, '0);
    check_value({tag, "_core_init"}, bus.core_init, 1'b0);
    check_value({tag, "_core_valid"}, bus.core_valid, 1'b0);
    check_value({tag, "_core_data"}, bus.core_data, 32'd0);
    check_value({tag, "_core_last"}, bus.core_last, 1'b0);
    check_value({tag, "_hash_valid"}, bus.hash_valid, 1'b0);
    check_value({tag, "_hash_data"}, bus.hash_data, 256'd0);
    check_value({tag, "_hash_err"}, bus.hash_err, 1'b0);
    check_value({tag, "_hash_id"}, bus.hash_id, '0);
  endtask

  initial begin
    int          n;
    int          base_cnt;
    int          base_init;
    logic [31:0] acc;
    word_t       w;
    exp_t        e;
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    bus.req_data = '0; bus.req_valid = '0; bus.req_last = '0; bus.req_numbyte = '0;
    bus.core_ready = 1'b0; bus.core_out_valid = 1'b0; bus.core_hash = '0; bus.hash_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Test 2: all requesters valid, one-word messages; grants 0,1,2,3,0.
    core_delay = 2; hr_en = 1'b1; ready_mode = 0;
    send(0, 1, 32'h10000000, 2'd1, 1'b0);
    send(1, 1, 32'h11111111, 2'd2, 1'b0);
    send(2, 1, 32'h22222222, 2'd3, 1'b0);
    send(3, 1, 32'h33333333, 2'd0, 1'b0);
    send(0, 1, 32'h40404040, 2'd1, 1'b0);
    wait_done(200);

    // Test 1: single requester 0, grant-to-accept latency and held result.
    core_delay = 3; hr_en = 1'b0; base_init = init_cnt; base_cnt = acc_cnt[0];
    send(0, 1, 32'h61626380, 2'd0, 1'b0);
    n = 0;
    do begin tick(); n++; end while (acc_cnt[0] == base_cnt && n < 20);
    check_value("grant_latency", n, 3);
    n = 0;
    do begin tick(); n++; end while (!bus.hash_valid && n < 40);
    check_value("hv_seen", bus.hash_valid, 1'b1);
    repeat (4) tick();
    check_value("hv_held", bus.hash_valid, 1'b1);
    hr_en = 1'b1;
    wait_done(50);
    check_value("t1_init_pulses", init_cnt - base_init, 1);
    check_value("t1_accepts", acc_cnt[0] - base_cnt, 1);

    // Test 3: requester 1 three words with toggling core_ready, requester 2 waiting.
    ready_mode = 1; core_delay = 4; base_cnt = acc_cnt[1];
    send(1, 3, 32'hA5A50001, 2'd3, 1'b0);
    send(2, 1, 32'h5A5A0002, 2'd2, 1'b0);
    wait_done(200);
    check_value("t3_accepts", acc_cnt[1] - base_cnt, 3);

    // Test 4: digest never arrives -> timeout after WAIT_MAX+1 WAIT cycles.
    ready_mode = 0; core_delay = 0;
    send(3, 1, 32'hDEAD0003, 2'd0, 1'b1);
    wait_done(100);
    check_value("t4_timeout_lat", t_hv - t_acc, WAIT_MAX + 2);

    // Test 5: digest arrives in the wait_cnt==WAIT_MAX cycle -> digest wins.
    core_delay = WAIT_MAX + 1;
    send(0, 2, 32'hBEEF0000, 2'd2, 1'b0);
    wait_done(100);
    check_value("t5_lat", t_hv - t_acc, WAIT_MAX + 2);

    // One cycle later the digest lands in DONE and must be ignored.
    core_delay = WAIT_MAX + 2;
    send(1, 1, 32'hCAFE0001, 2'd1, 1'b1);
    wait_done(100);

    // Test 6: reset during FEED of requester 2, then the rest of the stream resumes.
    core_delay = 2; base_cnt = acc_cnt[2];
    acc = 32'd0;
    for (int k = 0; k < 4; k++) begin
      w.data = 32'h70000000 + 32'(k); w.last = (k == 3); w.nb = (k == 3) ? 2'd3 : 2'd0;
      rq[2].push_back(w);
      if (k >= 2) acc = mix(acc, w);
    end
    e.id = IDW'(2); e.err = 1'b0; e.data = digest(acc);
    sb.push_back(e);
    n = 0;
    do begin tick(); n++; end while (acc_cnt[2] - base_cnt < 2 && n < 20);
    check_value("t6_pre_accepts", acc_cnt[2] - base_cnt, 2);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    owner = -1; inited = 1'b0; pend = 0; hv_hold = 1'b0; hv_prev = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    base_init = init_cnt;
    wait_done(100);
    check_value("t6_init_pulses", init_cnt - base_init, 1);
    check_value("t6_accepts", acc_cnt[2] - base_cnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
